// File: rtl/fetch_pc_unit.sv
// Instruction-fetch stage: PC register, next-PC select and F/D register.
// Delayed-branch pipeline; redirects come from the D-stage controls.
module fetch_pc_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        D_branch,
    input  logic        judge,
    input  logic        D_jump,
    input  logic        D_jr,
    input  logic [31:0] D_rs_data,
    input  logic [31:0] i_instr,
    output logic [31:0] F_pc,
    output logic [31:0] D_instr,
    output logic [31:0] D_pc,
    output logic [31:0] D_pc8,
    output logic [31:0] fetch_count
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] dpc_q, dpc_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] d_pc_plus4;
    logic [31:0] br_off;
    logic [31:0] next_pc;

    assign d_pc_plus4 = dpc_q + 32'd4;
    assign br_off     = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};

    // Next-PC select: jr, then j/jal, then taken branch, else sequential.
    always_comb begin
        next_pc = pc_q + 32'd4;
        if (D_jr) begin
            next_pc = {D_rs_data[31:2], 2'b00};
        end else if (D_jump) begin
            next_pc = {d_pc_plus4[31:28], instr_q[25:0], 2'b00};
        end else if (D_branch && judge) begin
            next_pc = d_pc_plus4 + br_off;
        end
    end

    // Stall freezes everything; the held D redirect is reapplied later.
    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        dpc_d   = dpc_q;
        cnt_d   = cnt_q;
        if (!stall) begin
            pc_d    = next_pc;
            instr_d = i_instr;
            dpc_d   = pc_q;
            cnt_d   = cnt_q + 32'd1;
        end
    end

    // State update; reset wins over stall and any pending redirect.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q    <= RESET_PC;
            instr_q <= 32'd0;
            dpc_q   <= 32'd0;
            cnt_q   <= 32'd0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            dpc_q   <= dpc_d;
            cnt_q   <= cnt_d;
        end
    end

    assign F_pc        = pc_q;
    assign D_instr     = instr_q;
    assign D_pc        = dpc_q;
    assign D_pc8       = dpc_q + 32'd8;
    assign fetch_count = cnt_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Self-checking bench for fetch_pc_unit.
// Directed scenarios plus a randomized run against a reference model.
module tb_fetch_pc_unit;

    localparam logic [31:0] RST_PC = 32'h0000_3000;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        D_branch;
    logic        judge;
    logic        D_jump;
    logic        D_jr;
    logic [31:0] D_rs_data;
    logic [31:0] i_instr;
    logic [31:0] F_pc;
    logic [31:0] D_instr;
    logic [31:0] D_pc;
    logic [31:0] D_pc8;
    logic [31:0] fetch_count;

    int n_cmp;
    int n_err;

    logic [31:0] m_pc, m_di, m_dpc, m_cnt;

    fetch_pc_unit #(.RESET_PC(RST_PC)) dut (
        .clk(clk),
        .reset(reset),
        .stall(stall),
        .D_branch(D_branch),
        .judge(judge),
        .D_jump(D_jump),
        .D_jr(D_jr),
        .D_rs_data(D_rs_data),
        .i_instr(i_instr),
        .F_pc(F_pc),
        .D_instr(D_instr),
        .D_pc(D_pc),
        .D_pc8(D_pc8),
        .fetch_count(fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: next state from the architectural rules, then one edge.
    task automatic edge_step();
        logic [31:0] tgt;
        logic signed [15:0] imm;
        int off;
        if (reset) begin
            m_pc  = RST_PC;
            m_di  = 32'd0;
            m_dpc = 32'd0;
            m_cnt = 32'd0;
        end else if (!stall) begin
            imm = m_di[15:0];
            off = imm;
            off = off * 4;
            if (D_jr)
                tgt = D_rs_data & 32'hFFFF_FFFC;
            else if (D_jump)
                tgt = ((m_dpc + 32'd4) & 32'hF000_0000)
                    | ((m_di & 32'h03FF_FFFF) << 2);
            else if (D_branch && judge)
                tgt = m_dpc + 32'd4 + 32'(off);
            else
                tgt = m_pc + 32'd4;
            m_dpc = m_pc;
            m_di  = i_instr;
            m_pc  = tgt;
            m_cnt = m_cnt + 32'd1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        stall     = 1'b0;
        D_branch  = 1'b0;
        judge     = 1'b0;
        D_jump    = 1'b0;
        D_jr      = 1'b0;
        D_rs_data = 32'd0;
        i_instr   = 32'd0;
    endtask

    task automatic do_reset();
        idle_in();
        reset = 1'b1;
        edge_step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        idle_in();
        reset = 1'b1;
        edge_step();
        edge_step();
        n_cmp++;
        if (F_pc !== 32'h3000) begin
            n_err++;
            $display("FAIL rst_fpc got %h want %h", F_pc, 32'h3000);
        end
        n_cmp++;
        if (D_instr !== 32'd0) begin
            n_err++;
            $display("FAIL rst_dinstr got %h want 0", D_instr);
        end
        n_cmp++;
        if (D_pc8 !== 32'd8 || D_pc !== 32'd0) begin
            n_err++;
            $display("FAIL rst_dpc got %h/%h want 0/8", D_pc, D_pc8);
        end
        n_cmp++;
        if (fetch_count !== 32'd0) begin
            n_err++;
            $display("FAIL rst_cnt got %0d want 0", fetch_count);
        end
        reset = 1'b0;
        repeat (3) edge_step();
        n_cmp++;
        if (F_pc !== 32'h300C || D_pc !== 32'h3008) begin
            n_err++;
            $display("FAIL seq_pc got %h/%h want 300c/3008", F_pc, D_pc);
        end
        n_cmp++;
        if (fetch_count !== 32'd3) begin
            n_err++;
            $display("FAIL seq_cnt got %0d want 3", fetch_count);
        end
    endtask

    task automatic test_branch_fwd();
        do_reset();
        edge_step();
        i_instr = 32'h1000_0003;
        edge_step();
        i_instr  = 32'd0;
        D_branch = 1'b1;
        judge    = 1'b1;
        edge_step();
        idle_in();
        n_cmp++;
        if (F_pc !== 32'h3014 || D_pc !== 32'h3008) begin
            n_err++;
            $display("FAIL beq_fwd got %h/%h want 3014/3008", F_pc, D_pc);
        end
    endtask

    task automatic test_bne();
        do_reset();
        edge_step();
        i_instr = 32'h1400_FFFF;
        edge_step();
        i_instr  = 32'd0;
        D_branch = 1'b1;
        judge    = 1'b0;
        edge_step();
        idle_in();
        n_cmp++;
        if (F_pc !== 32'h300C) begin
            n_err++;
            $display("FAIL bne_nt got %h want 300c", F_pc);
        end
        edge_step();
        i_instr = 32'h1400_FFFF;
        edge_step();
        i_instr  = 32'd0;
        D_branch = 1'b1;
        judge    = 1'b1;
        edge_step();
        idle_in();
        n_cmp++;
        if (F_pc !== 32'h3010 || D_pc !== 32'h3014) begin
            n_err++;
            $display("FAIL bne_bwd got %h/%h want 3010/3014", F_pc, D_pc);
        end
    endtask

    task automatic test_stall();
        do_reset();
        edge_step();
        i_instr = 32'h1000_0004;
        edge_step();
        i_instr  = 32'hDEAD_0000;
        D_branch = 1'b1;
        judge    = 1'b1;
        stall    = 1'b1;
        repeat (2) edge_step();
        n_cmp++;
        if (F_pc !== 32'h3008 || D_pc !== 32'h3004) begin
            n_err++;
            $display("FAIL stall_pc got %h/%h want 3008/3004", F_pc, D_pc);
        end
        n_cmp++;
        if (D_instr !== 32'h1000_0004 || fetch_count !== 32'd2) begin
            n_err++;
            $display("FAIL stall_hold got %h/%0d want 10000004/2",
                     D_instr, fetch_count);
        end
        stall = 1'b0;
        edge_step();
        idle_in();
        n_cmp++;
        if (F_pc !== 32'h3018 || D_instr !== 32'hDEAD_0000) begin
            n_err++;
            $display("FAIL stall_rel got %h/%h want 3018/dead0000",
                     F_pc, D_instr);
        end
        n_cmp++;
        if (fetch_count !== 32'd3) begin
            n_err++;
            $display("FAIL stall_cnt got %0d want 3", fetch_count);
        end
    endtask

    task automatic test_jal_jr();
        idle_in();
        reset   = 1'b1;
        i_instr = 32'h0C00_0D00;
        edge_step();
        reset = 1'b0;
        edge_step();
        n_cmp++;
        if (D_pc8 !== 32'h3008) begin
            n_err++;
            $display("FAIL jal_link got %h want 3008", D_pc8);
        end
        i_instr = 32'd0;
        D_jump  = 1'b1;
        edge_step();
        D_jump    = 1'b0;
        n_cmp++;
        if (F_pc !== 32'h3400) begin
            n_err++;
            $display("FAIL jal_tgt got %h want 3400", F_pc);
        end
        D_jr      = 1'b1;
        D_rs_data = 32'h3402;
        edge_step();
        idle_in();
        n_cmp++;
        if (F_pc !== 32'h3400) begin
            n_err++;
            $display("FAIL jr_tgt got %h want 3400", F_pc);
        end
    endtask

    task automatic test_reset_midstall();
        do_reset();
        i_instr = 32'h0800_0123;
        repeat (3) edge_step();
        stall  = 1'b1;
        D_jump = 1'b1;
        reset  = 1'b1;
        edge_step();
        reset = 1'b0;
        idle_in();
        n_cmp++;
        if (F_pc !== 32'h3000 || D_instr !== 32'd0) begin
            n_err++;
            $display("FAIL rst_stall got %h/%h want 3000/0", F_pc, D_instr);
        end
        n_cmp++;
        if (fetch_count !== 32'd0) begin
            n_err++;
            $display("FAIL rst_stall_cnt got %0d want 0", fetch_count);
        end
    endtask

    task automatic test_random();
        int sel;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            reset     = ($urandom_range(0, 49) == 0);
            stall     = ($urandom_range(0, 3) == 0);
            sel       = $urandom_range(0, 9);
            D_jr      = (sel == 0) || (sel == 9);
            D_jump    = (sel == 1) || (sel == 9);
            D_branch  = (sel inside {[2:4]}) || (sel == 9);
            judge     = $urandom_range(0, 1) == 1;
            D_rs_data = $urandom;
            i_instr   = $urandom;
            edge_step();
            n_cmp++;
            if (F_pc !== m_pc) begin
                n_err++;
                $display("FAIL rnd_fpc[%0d] got %h want %h", i, F_pc, m_pc);
            end
            n_cmp++;
            if (D_instr !== m_di) begin
                n_err++;
                $display("FAIL rnd_di[%0d] got %h want %h", i, D_instr, m_di);
            end
            n_cmp++;
            if (D_pc !== m_dpc) begin
                n_err++;
                $display("FAIL rnd_dpc[%0d] got %h want %h", i, D_pc, m_dpc);
            end
            n_cmp++;
            if (D_pc8 !== m_dpc + 32'd8) begin
                n_err++;
                $display("FAIL rnd_pc8[%0d] got %h want %h",
                         i, D_pc8, m_dpc + 32'd8);
            end
            n_cmp++;
            if (fetch_count !== m_cnt) begin
                n_err++;
                $display("FAIL rnd_cnt[%0d] got %0d want %0d",
                         i, fetch_count, m_cnt);
            end
        end
        idle_in();
        reset = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        m_pc  = RST_PC;
        m_di  = 32'd0;
        m_dpc = 32'd0;
        m_cnt = 32'd0;
        reset = 1'b1;
        idle_in();
        #2;
        test_reset();
        test_branch_fwd();
        test_bne();
        test_stall();
        test_jal_jr();
        test_reset_midstall();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_pc_unit.md
# fetch_pc_unit

Instruction-fetch stage of the micro MIPS pipeline: holds the PC, addresses instruction memory, and registers the fetched word into the F/D pipeline register. It consumes the D-stage branch decision produced by the D-stage comparator (`judge`), together with decoded jump and jump-register controls, to select the next PC. Delayed-branch semantics apply: the instruction after a branch or jump always executes. A free-running fetch counter is provided for performance monitoring.

## Interface
- `RESET_PC`, 32'h0000_3000, PC value loaded on reset.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `stall`  in  1  hazard-unit stall; freezes the PC, F/D register and counter.
- `D_branch`  in  1  the D-stage instruction is beq or bne.
- `judge`  in  1  branch condition result from the D-stage comparator.
- `D_jump`  in  1  the D-stage instruction is j or jal.
- `D_jr`  in  1  the D-stage instruction is jr.
- `D_rs_data`  in  32  forwarded rs value; this is the jr target.
- `i_instr`  in  32  instruction-memory read data for `F_pc`; combinational.
- `F_pc`  out  32  current fetch address, driven to instruction memory.
- `D_instr`  out  32  F/D registered instruction.
- `D_pc`  out  32  F/D registered PC of `D_instr`.
- `D_pc8`  out  32  `D_pc + 8`; the link address for jal.
- `fetch_count`  out  32  number of instructions accepted into F/D since reset.

## Operation
- **Registers:** PC (32), D_instr (32), D_pc (32), fetch_count (32). `D_pc8` is combinational from `D_pc`.
- **Next-PC selection:** evaluated from D-stage controls, priority top to bottom.
  - `D_jr`: `{D_rs_data[31:2], 2'b00}`. The low two bits are always forced to zero.
  - `D_jump`: `{D_pc_plus4[31:28], D_instr[25:0], 2'b00}`, where `D_pc_plus4 = D_pc + 4`.
  - `D_branch && judge`: `D_pc + 4 + {{14{D_instr[15]}}, D_instr[15:0], 2'b00}`. All arithmetic is 32-bit modulo 2^32, with no overflow detection.
  - Otherwise: `F_pc + 4`.
  - The decoder guarantees the controls are one-hot. The priority order above still defines behaviour if more than one is asserted.
- **Delayed branch:** while a branch or jump sits in D, F holds its delay slot. At the same edge, F/D captures the delay slot and the PC loads the target. No flush exists.
- **Stall:** when `stall` = 1, PC, D_instr, D_pc and fetch_count all hold.
  - Redirect controls are ignored while stalled. Because the D instruction is held, the redirect is recomputed and applied at the first non-stalled edge.
- **Counter:** `fetch_count` increments by 1 on every non-stalled, non-reset edge. It wraps from 32'hFFFF_FFFF to 0.
- **Reset:** has priority over `stall`. It applies PC = `RESET_PC`, D_instr = 0 (nop), D_pc = 0 and fetch_count = 0.
  - Asserting reset mid-operation, including during a stall or with a pending redirect, discards all state at that edge.

## Timing
- Reset values: `F_pc` = 32'h0000_3000, `D_instr` = 0, `D_pc` = 0, `D_pc8` = 8, `fetch_count` = 0.
- Instruction-memory read is combinational. The word fetched at `F_pc` in cycle n appears on `D_instr` in cycle n+1.
- Redirect latency: a branch or jump in D during cycle n produces `F_pc` = target in cycle n+1. This is one delay slot and zero bubbles.
- First edge after reset deassertion: `F_pc` goes to `RESET_PC + 4`, `D_pc` to `RESET_PC`, and `fetch_count` to 1.
- `stall` and the D controls are sampled only at the rising edge. No combinational path exists from `stall` to any output.

## Test plan
- **Reset and sequential fetch:** hold reset 2 cycles, then release for 3 cycles with no controls. Expect `F_pc` = 0x300C, `D_pc` = 0x3008, `fetch_count` = 3. During reset expect `F_pc` = 0x3000 and `D_instr` = 0.
- **beq taken, forward:** `D_pc` = 0x3004, `D_instr[15:0]` = 0x0003, `D_branch` = 1, `judge` = 1. Next cycle expect `F_pc` = 0x3014 and `D_pc` = 0x3008 (the delay slot).
- **bne not taken, then backward taken:**
  - `judge` = 0 with `F_pc` = 0x3008: next `F_pc` = 0x300C.
  - `judge` = 1, imm = 0xFFFF, `D_pc` = 0x3010: next `F_pc` = 0x3010.
- **Stall over a branch:** taken branch in D with `stall` = 1 for 2 cycles. `F_pc`, `D_instr`, `D_pc` and `fetch_count` stay unchanged. Expect the target on `F_pc` in the cycle after `stall` drops.
- **jal and jr:**
  - jal with `D_pc` = 0x3000, index = 0x0000D00: expect `F_pc` = 0x3400 and `D_pc8` = 0x3008.
  - jr with `D_rs_data` = 0x3402: expect `F_pc` = 0x3400 (low bits forced to zero).
- **Reset mid-stall with redirect pending:** `stall` = 1, `D_jump` = 1, `reset` = 1 on the same edge. Expect `F_pc` = 0x3000, `D_instr` = 0, `fetch_count` = 0.
